// File: rtl/blvds_frame_writer_pkg.sv
// BLVDS frame writer: shared constants and state encoding.
// The uPP reader also imports this package.
package blvds_frame_writer_pkg;

    localparam logic [15:0] SYNC_WORD_DEF   = 16'hA5A5;
    localparam logic [8:0]  FRAME_WORDS_DEF = 9'd256;
    localparam logic [8:0]  TIMEOUT_DEF     = 9'd500;

    typedef enum logic [1:0] {
        ST_HUNT    = 2'd0,
        ST_PAYLOAD = 2'd1,
        ST_DONE    = 2'd2
    } fw_state_e;

    function automatic logic [8:0] sat_inc9(
        input logic [8:0] v,
        input logic [8:0] lim
    );
        return (v >= lim) ? lim : v + 9'd1;
    endfunction

endpackage

// File: rtl/blvds_frame_writer_watchdog.sv
// Payload idle counter: clears on activity, saturates,
// flags expiry on the cycle the count reaches TIMEOUT.
module blvds_frame_writer_watchdog
    import blvds_frame_writer_pkg::*;
#(
    parameter logic [8:0] TIMEOUT = TIMEOUT_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic clr,
    output logic expire
);

    logic [8:0] idle_q;
    logic [8:0] idle_d;

    always_comb begin
        idle_d = idle_q;
        if (!en || clr) begin
            idle_d = 9'd0;
        end else begin
            idle_d = sat_inc9(idle_q, TIMEOUT);
        end
    end

    assign expire = en && !clr && (idle_d == TIMEOUT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idle_q <= 9'd0;
        end else begin
            idle_q <= idle_d;
        end
    end

endmodule

// File: rtl/blvds_frame_writer.sv
// Hunts for a sync word, forwards a fixed-length payload
// into a FIFO, and signals frame end / overflow / timeout.
module blvds_frame_writer
    import blvds_frame_writer_pkg::*;
#(
    parameter logic [15:0] SYNC_WORD   = SYNC_WORD_DEF,
    parameter logic [8:0]  FRAME_WORDS = FRAME_WORDS_DEF,
    parameter logic [8:0]  TIMEOUT     = TIMEOUT_DEF
) (
    input  logic        iCLK,
    input  logic        iRST_N,
    input  logic [15:0] iDATA,
    input  logic        iVALID,
    input  logic        iFULL,
    output logic [15:0] oDATA,
    output logic        oWR_REQ,
    output logic        oFRAME_END,
    output logic        oOVF,
    output logic        oTMO,
    output logic [15:0] oFRAME_CNT
);

    fw_state_e   state_q;
    fw_state_e   state_d;
    logic [8:0]  wcnt_q;
    logic [8:0]  wcnt_d;
    logic [8:0]  wcnt_inc;
    logic        wr_q;
    logic        wr_d;
    logic [15:0] data_q;
    logic [15:0] data_d;
    logic        ovf_q;
    logic        ovf_d;
    logic        tmo_q;
    logic        tmo_d;
    logic [15:0] frame_cnt_q;
    logic [15:0] frame_cnt_d;
    logic        expire;

    blvds_frame_writer_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk    (iCLK),
        .rst_n  (iRST_N),
        .en     (state_q == ST_PAYLOAD),
        .clr    (iVALID),
        .expire (expire)
    );

    assign wcnt_inc = wcnt_q + 9'd1;

    always_comb begin
        state_d     = state_q;
        wcnt_d      = wcnt_q;
        wr_d        = 1'b0;
        data_d      = data_q;
        ovf_d       = ovf_q;
        tmo_d       = 1'b0;
        frame_cnt_d = frame_cnt_q;
        unique case (state_q)
            ST_HUNT: begin
                if (iVALID && (iDATA == SYNC_WORD)) begin
                    state_d = ST_PAYLOAD;
                    wcnt_d  = 9'd0;
                    ovf_d   = 1'b0;
                end
            end
            ST_PAYLOAD: begin
                if (iVALID) begin
                    wcnt_d = wcnt_inc;
                    if (iFULL) begin
                        ovf_d = 1'b1;
                    end else begin
                        wr_d   = 1'b1;
                        data_d = iDATA;
                    end
                    if (wcnt_inc == FRAME_WORDS) begin
                        state_d = ST_DONE;
                    end
                end else if (expire) begin
                    // partial frame: reader is told to flush
                    state_d = ST_HUNT;
                    tmo_d   = 1'b1;
                end
            end
            ST_DONE: begin
                frame_cnt_d = frame_cnt_q + 16'd1;
                state_d     = ST_HUNT;
            end
            default: begin
                state_d = ST_HUNT;
            end
        endcase
    end

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            state_q     <= ST_HUNT;
            wcnt_q      <= 9'd0;
            wr_q        <= 1'b0;
            data_q      <= 16'd0;
            ovf_q       <= 1'b0;
            tmo_q       <= 1'b0;
            frame_cnt_q <= 16'd0;
        end else begin
            state_q     <= state_d;
            wcnt_q      <= wcnt_d;
            wr_q        <= wr_d;
            data_q      <= data_d;
            ovf_q       <= ovf_d;
            tmo_q       <= tmo_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign oDATA      = data_q;
    assign oWR_REQ    = wr_q;
    assign oFRAME_END = (state_q == ST_DONE) || tmo_q;
    assign oOVF       = ovf_q;
    assign oTMO       = tmo_q;
    assign oFRAME_CNT = frame_cnt_q;

endmodule

// File: tb/tb_blvds_frame_writer.sv
// Directed bench for blvds_frame_writer: vector table plus
// frame-level sequences checked by a write scoreboard.
module tb_blvds_frame_writer;

    logic        iCLK   = 1'b0;
    logic        iRST_N = 1'b1;
    logic [15:0] iDATA  = 16'd0;
    logic        iVALID = 1'b0;
    logic        iFULL  = 1'b0;
    logic [15:0] oDATA;
    logic        oWR_REQ;
    logic        oFRAME_END;
    logic        oOVF;
    logic        oTMO;
    logic [15:0] oFRAME_CNT;

    blvds_frame_writer dut (
        .iCLK       (iCLK),
        .iRST_N     (iRST_N),
        .iDATA      (iDATA),
        .iVALID     (iVALID),
        .iFULL      (iFULL),
        .oDATA      (oDATA),
        .oWR_REQ    (oWR_REQ),
        .oFRAME_END (oFRAME_END),
        .oOVF       (oOVF),
        .oTMO       (oTMO),
        .oFRAME_CNT (oFRAME_CNT)
    );

    always #5 iCLK = ~iCLK;

    int          checks   = 0;
    int          failures = 0;
    int          fe_cnt   = 0;
    int          tmo_cnt  = 0;
    int          wr_cnt   = 0;
    bit          mon_en   = 1'b0;
    logic [15:0] exp_q[$];
    logic [15:0] mon_e;

    typedef struct {
        logic        v;
        logic        f;
        logic [15:0] d;
        logic        ewr;
        logic [15:0] edat;
        logic        eovf;
        logic        efe;
    } vec_t;

    vec_t tbl[9];

    task automatic chk(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic put(input logic v,
                       input logic [15:0] d,
                       input logic f);
        @(negedge iCLK);
        iVALID = v;
        iDATA  = d;
        iFULL  = f;
    endtask

    task automatic send_frame(input int flo,
                              input int fhi,
                              input bit sync5,
                              input logic [15:0] exp_cnt,
                              input bit exp_ovf);
        int fe0;
        logic [15:0] d;
        logic f;
        fe0 = fe_cnt;
        put(1'b1, 16'hA5A5, 1'b0);
        for (int i = 0; i < 256; i++) begin
            d = (sync5 && i == 5) ? 16'hA5A5 : 16'(i);
            f = (i >= flo) && (i <= fhi);
            if (!f) exp_q.push_back(d);
            put(1'b1, d, f);
            if (i == 0) chk("ovf_clr_on_sync", 32'(oOVF), 0);
        end
        put(1'b1, 16'hBEEF, 1'b0);
        put(1'b0, 16'h0, 1'b0);
        put(1'b0, 16'h0, 1'b0);
        put(1'b0, 16'h0, 1'b0);
        chk("frame_end_once", fe_cnt - fe0, 1);
        chk("writes_drained", exp_q.size(), 0);
        chk("frame_cnt", 32'(oFRAME_CNT), 32'(exp_cnt));
        chk("ovf_after_frame", 32'(oOVF), 32'(exp_ovf));
    endtask

    always @(negedge iCLK) begin
        if (mon_en) begin
            if (oWR_REQ) begin
                wr_cnt++;
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_wr: got %0h want none",
                             oDATA);
                end else begin
                    mon_e = exp_q.pop_front();
                    if (oDATA !== mon_e) begin
                        failures++;
                        $display("FAIL wr_data: got %0h want %0h",
                                 oDATA, mon_e);
                    end
                end
            end
            if (oFRAME_END) fe_cnt++;
            if (oTMO) begin
                tmo_cnt++;
                checks++;
                if (!oFRAME_END) begin
                    failures++;
                    $display("FAIL tmo_with_fe: got 0 want 1");
                end
            end
        end
    end

    initial begin
        int w0;
        int fe0;
        int t0;
        int k;

        tbl[0] = '{1'b1, 1'b0, 16'h1234, 1'b0, 16'h0,    1'b0, 1'b0};
        tbl[1] = '{1'b0, 1'b0, 16'h0000, 1'b0, 16'h0,    1'b0, 1'b0};
        tbl[2] = '{1'b1, 1'b0, 16'hA5A5, 1'b0, 16'h0,    1'b0, 1'b0};
        tbl[3] = '{1'b1, 1'b0, 16'h0011, 1'b1, 16'h0011, 1'b0, 1'b0};
        tbl[4] = '{1'b0, 1'b0, 16'h9999, 1'b0, 16'h0,    1'b0, 1'b0};
        tbl[5] = '{1'b1, 1'b0, 16'hA5A5, 1'b1, 16'hA5A5, 1'b0, 1'b0};
        tbl[6] = '{1'b1, 1'b1, 16'h7777, 1'b0, 16'h0,    1'b1, 1'b0};
        tbl[7] = '{1'b1, 1'b0, 16'h0022, 1'b1, 16'h0022, 1'b1, 1'b0};
        tbl[8] = '{1'b0, 1'b1, 16'h0000, 1'b0, 16'h0,    1'b1, 1'b0};

        #1 iRST_N = 1'b0;
        repeat (3) @(negedge iCLK);
        chk("rst_wr",   32'(oWR_REQ), 0);
        chk("rst_data", 32'(oDATA), 0);
        chk("rst_fe",   32'(oFRAME_END), 0);
        chk("rst_ovf",  32'(oOVF), 0);
        chk("rst_tmo",  32'(oTMO), 0);
        chk("rst_cnt",  32'(oFRAME_CNT), 0);
        iRST_N = 1'b1;

        for (int i = 0; i < 9; i++) begin
            put(tbl[i].v, tbl[i].d, tbl[i].f);
            @(posedge iCLK);
            #1;
            chk($sformatf("tbl%0d_wr", i),
                32'(oWR_REQ), 32'(tbl[i].ewr));
            if (tbl[i].ewr)
                chk($sformatf("tbl%0d_data", i),
                    32'(oDATA), 32'(tbl[i].edat));
            chk($sformatf("tbl%0d_ovf", i),
                32'(oOVF), 32'(tbl[i].eovf));
            chk($sformatf("tbl%0d_fe", i),
                32'(oFRAME_END), 32'(tbl[i].efe));
        end

        #2 iRST_N = 1'b0;
        #1;
        chk("midrst_ovf", 32'(oOVF), 0);
        chk("midrst_data", 32'(oDATA), 0);
        @(negedge iCLK);
        iRST_N = 1'b1;
        mon_en = 1'b1;

        send_frame(999, 0, 1'b0, 16'd1, 1'b0);

        w0 = wr_cnt;
        for (int i = 0; i < 10; i++) put(1'b1, 16'h1234, 1'b0);
        put(1'b0, 16'h0, 1'b0);
        chk("no_wr_in_hunt", wr_cnt - w0, 0);
        send_frame(999, 0, 1'b1, 16'd2, 1'b0);

        w0 = wr_cnt;
        send_frame(100, 103, 1'b0, 16'd3, 1'b1);
        chk("ovf_frame_writes", wr_cnt - w0, 252);

        w0 = wr_cnt;
        send_frame(255, 255, 1'b0, 16'd4, 1'b1);
        chk("last_full_writes", wr_cnt - w0, 255);

        fe0 = fe_cnt;
        t0  = tmo_cnt;
        put(1'b1, 16'hA5A5, 1'b0);
        for (int i = 0; i < 40; i++) begin
            exp_q.push_back(16'(i + 16'h300));
            put(1'b1, 16'(i + 16'h300), 1'b0);
        end
        k = 0;
        for (int j = 1; j <= 600 && k == 0; j++) begin
            put(1'b0, 16'h0, 1'b0);
            @(posedge iCLK);
            #1;
            if (oTMO) begin
                k = j;
                chk("tmo_fe_same", 32'(oFRAME_END), 1);
            end
        end
        chk("tmo_idle_cycles", k, 500);
        put(1'b0, 16'h0, 1'b0);
        put(1'b0, 16'h0, 1'b0);
        chk("tmo_pulse_once", tmo_cnt - t0, 1);
        chk("tmo_fe_once", fe_cnt - fe0, 1);
        chk("tmo_cnt_hold", 32'(oFRAME_CNT), 4);
        chk("tmo_drained", exp_q.size(), 0);
        w0 = wr_cnt;
        put(1'b1, 16'h0055, 1'b0);
        put(1'b0, 16'h0, 1'b0);
        put(1'b0, 16'h0, 1'b0);
        chk("tmo_back_hunt", wr_cnt - w0, 0);

        fe0 = fe_cnt;
        put(1'b1, 16'hA5A5, 1'b0);
        for (int i = 0; i < 128; i++) begin
            if (i != 10 && i != 127) exp_q.push_back(16'(i));
            put(1'b1, 16'(i), i == 10);
        end
        @(posedge iCLK);
        #2;
        chk("pre_rst_wr", 32'(oWR_REQ), 1);
        iRST_N = 1'b0;
        #1;
        chk("arst_wr",   32'(oWR_REQ), 0);
        chk("arst_data", 32'(oDATA), 0);
        chk("arst_ovf",  32'(oOVF), 0);
        chk("arst_fe",   32'(oFRAME_END), 0);
        chk("arst_tmo",  32'(oTMO), 0);
        chk("arst_cnt",  32'(oFRAME_CNT), 0);
        chk("arst_drained", exp_q.size(), 0);
        put(1'b0, 16'h0, 1'b0);
        put(1'b0, 16'h0, 1'b0);
        @(negedge iCLK);
        iRST_N = 1'b1;
        chk("arst_no_fe", fe_cnt - fe0, 0);
        w0 = wr_cnt;
        for (int i = 0; i < 5; i++) put(1'b1, 16'(i + 129), 1'b0);
        put(1'b0, 16'h0, 1'b0);
        chk("post_rst_needs_sync", wr_cnt - w0, 0);
        send_frame(999, 0, 1'b0, 16'd1, 1'b0);

        @(negedge iCLK);
        force dut.frame_cnt_q = 16'hFFFF;
        @(negedge iCLK);
        release dut.frame_cnt_q;
        chk("cnt_preload", 32'(oFRAME_CNT), 32'hFFFF);
        send_frame(999, 0, 1'b0, 16'd0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/blvds_frame_writer.md
BLVDS_FRAME_WRITER -- requirements
Module: blvds_frame_writer

Interface
REQ-001 Parameter SYNC_WORD, default 16'hA5A5, frame start marker on the BLVDS word stream.
REQ-002 Parameter FRAME_WORDS, default 9'd256, payload words per frame (range 1..256).
REQ-003 Parameter TIMEOUT, default 9'd500, idle cycles inside a payload before the frame is aborted.
REQ-004 Port iCLK  input  1  sole clock; all logic on its rising edge.
REQ-005 Port iRST_N  input  1  reset, asynchronous, active-low.
REQ-006 Port iDATA  input  16  deserialized BLVDS word.
REQ-007 Port iVALID  input  1  iDATA valid this cycle.
REQ-008 Port iFULL  input  1  downstream FIFO full.
REQ-009 Port oDATA  output  16  FIFO write data.
REQ-010 Port oWR_REQ  output  1  FIFO write strobe.
REQ-011 Port oFRAME_END  output  1  one-cycle pulse, frame written; drives the uPP reader start input.
REQ-012 Port oOVF  output  1  sticky, at least one payload word dropped on iFULL in the current or last frame.
REQ-013 Port oTMO  output  1  one-cycle pulse, payload aborted by timeout.
REQ-014 Port oFRAME_CNT  output  16  completed-frame counter, wraps 16'hFFFF -> 0.

Function
REQ-015 States: HUNT, PAYLOAD, DONE; any illegal encoding SHALL return to HUNT next cycle.
REQ-016 HUNT: iVALID && iDATA==SYNC_WORD -> PAYLOAD, word counter cleared, oOVF cleared; sync word not written; other words ignored.
REQ-017 PAYLOAD: each iVALID word SHALL increment the word counter; written (oWR_REQ=1, oDATA=iDATA on next edge, latency 1 cycle) only if iFULL=0, else dropped and oOVF set.
REQ-018 A SYNC_WORD value inside PAYLOAD SHALL be treated as ordinary data.
REQ-019 On the valid word making the count equal FRAME_WORDS -> DONE.
REQ-020 DONE: oFRAME_END=1 for exactly one cycle, oFRAME_CNT+1, -> HUNT; iVALID words in DONE are ignored.
REQ-021 PAYLOAD idle counter: cleared on each iVALID, increments otherwise; reaching TIMEOUT -> HUNT with oTMO and oFRAME_END pulsed together (reader flushes partial data), oFRAME_CNT unchanged.
REQ-022 oWR_REQ SHALL be 0 in every cycle not following an accepted payload word; never asserted while the registered iFULL sample was 1.
REQ-023 Word counter 9 bits, never exceeds FRAME_WORDS; idle counter saturates at TIMEOUT.
REQ-024 Simultaneous last word and iFULL: word dropped, oOVF set, frame still completes via DONE.

Reset
REQ-025 iRST_N=0 SHALL force HUNT and all outputs and counters to 0 immediately, including mid-frame; no oFRAME_END emitted for the aborted frame.
REQ-026 After release, first action requires a fresh SYNC_WORD.

Structure
REQ-027 Shared package holds SYNC_WORD, FRAME_WORDS and TIMEOUT defaults and the state encoding, shared with the uPP reader.
REQ-028 One sub-module natural: frame_watchdog (idle counter with clear/saturate/expire); remainder in one FSM module.

Verification
REQ-029 Sync, then 256 valid words 0..255, iFULL=0 -> 256 writes of 0..255 one cycle late, one oFRAME_END, oFRAME_CNT=1.
REQ-030 Words 16'h1234 ×10 before sync -> no writes; sync word 16'hA5A5 at payload word 5 -> written as data.
REQ-031 iFULL=1 during words 100..103 -> 252 writes, oOVF=1 until next sync, oFRAME_END still pulses.
REQ-032 Sync, 40 words, then iVALID=0 for 500 cycles -> oTMO and oFRAME_END pulse same cycle, oFRAME_CNT unchanged, back to HUNT.
REQ-033 iRST_N low at payload word 128 -> outputs 0 at once; after release, next full frame gives oFRAME_CNT=1.
REQ-034 Preload oFRAME_CNT path with 65535 frames (or forced counter) -> next frame wraps to 0.
